// File: rtl/imem_wb_loader.sv
// rtl/imem_wb_loader.sv - Wishbone loader for the 32x512 instruction SRAM port 0 plus core-hold CTRL register
// Optional macro IMEM_READBACK_EN builds the SRAM read path for memory-window reads.
module imem_wb_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              wb_clk_i,
    input  logic              rst_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              csb0,
    output logic              web0,
    output logic [3:0]        wmask0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0,
    output logic              core_reset_o,
    output logic              load_busy_o
);

`ifdef IMEM_READBACK_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_ACK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_ACK = 2'd3} state_t;
    logic unused_dout;
    assign unused_dout = ^dout0;
`endif

    state_t              state_q;
    logic                ack_q;
    logic [31:0]         dat_q;
    logic                csb0_q;
    logic                web0_q;
    logic [3:0]          wmask0_q;
    logic [ADDR_W-1:0]   addr0_q;
    logic [DATA_W-1:0]   din0_q;
    logic                hold_q;
    logic                wseen_q;
    logic [15:0]         wcnt_q;
    logic                abort_q;

    logic        in_blk;
    logic        hit_mem;
    logic        hit_ctrl;
    logic        req;
    logic        keep_ack;
    logic [31:0] ctrl_rd;

    assign in_blk   = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign hit_mem  = in_blk && !wbs_adr_i[11];
    assign hit_ctrl = in_blk && (wbs_adr_i[11:0] == 12'h800);
    assign req      = wbs_cyc_i && wbs_stb_i && in_blk;
    // A master that dropped cyc at any point during the access gets no ack.
    assign keep_ack = wbs_cyc_i && !abort_q;
    assign ctrl_rd  = {wcnt_q, 14'd0, wseen_q, hold_q};

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            csb0_q   <= 1'b1;
            web0_q   <= 1'b1;
            wmask0_q <= 4'd0;
            addr0_q  <= '0;
            din0_q   <= '0;
            hold_q   <= 1'b1;
            wseen_q  <= 1'b0;
            wcnt_q   <= 16'd0;
            abort_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    abort_q <= 1'b0;
                    dat_q   <= 32'd0;
                    if (req) begin
                        if (hit_mem && wbs_we_i) begin
                            state_q  <= S_ISSUE;
                            csb0_q   <= (wbs_sel_i == 4'd0);
                            web0_q   <= 1'b0;
                            wmask0_q <= wbs_sel_i;
                            addr0_q  <= wbs_adr_i[ADDR_W+1:2];
                            din0_q   <= wbs_dat_i;
                            if (wbs_sel_i != 4'd0) begin
                                wseen_q <= 1'b1;
                                if (wcnt_q != 16'hFFFF) begin
                                    wcnt_q <= wcnt_q + 16'd1;
                                end
                            end
`ifdef IMEM_READBACK_EN
                        end else if (hit_mem) begin
                            state_q <= S_ISSUE;
                            csb0_q  <= 1'b0;
                            web0_q  <= 1'b1;
                            addr0_q <= wbs_adr_i[ADDR_W+1:2];
`endif
                        end else begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                            if (hit_ctrl && !wbs_we_i) begin
                                dat_q <= ctrl_rd;
                            end
                            if (hit_ctrl && wbs_we_i && wbs_sel_i[0]) begin
                                hold_q <= wbs_dat_i[0];
                                if (wbs_dat_i[1]) begin
                                    wseen_q <= 1'b0;
                                    wcnt_q  <= 16'd0;
                                end
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    csb0_q <= 1'b1;
                    web0_q <= 1'b1;
`ifdef IMEM_READBACK_EN
                    if (web0_q) begin
                        state_q <= S_WAIT;
                        abort_q <= abort_q | ~wbs_cyc_i;
                    end else
`endif
                    begin
                        if (keep_ack) begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
`ifdef IMEM_READBACK_EN
                S_WAIT: begin
                    if (keep_ack) begin
                        state_q <= S_ACK;
                        ack_q   <= 1'b1;
                        dat_q   <= dout0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
`endif
                S_ACK: begin
                    state_q <= S_IDLE;
                    dat_q   <= 32'd0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign csb0         = csb0_q;
    assign web0         = web0_q;
    assign wmask0       = wmask0_q;
    assign addr0        = addr0_q;
    assign din0         = din0_q;
    assign core_reset_o = hold_q;
    assign load_busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_imem_wb_loader.sv
// tb/tb_imem_wb_loader.sv - self-checking bench for imem_wb_loader against a transaction-level model
module tb_imem_wb_loader;
`ifdef IMEM_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'd0;
    logic [31:0] wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic [31:0] dout0 = 32'd0;
    logic        core_reset_o, load_busy_o;

    imem_wb_loader dut (
        .wb_clk_i(wb_clk_i), .rst_n(rst_n),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .core_reset_o(core_reset_o), .load_busy_o(load_busy_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    // SRAM macro behaviour: synchronous, registered read data.
    logic [31:0] sram [0:511];
    always @(posedge wb_clk_i) begin
        if (!csb0 && !web0) begin
            for (int b = 0; b < 4; b++)
                if (wmask0[b]) sram[addr0][8*b +: 8] <= din0[8*b +: 8];
        end
        if (!csb0 && web0) dout0 <= sram[addr0];
    end

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [0:511];
    int          m_hold = 1, m_wseen = 0, m_wcnt = 0;

    int          e_req = 0, e_busy_end = 0, e_ack_cyc = -1, e_sram_cyc = -1;
    logic [31:0] e_dat = 32'd0, e_din = 32'd0;
    logic [8:0]  e_addr = 9'd0;
    logic [3:0]  e_mask = 4'd0;
    logic        e_we = 1'b0;
    bit          chk_en = 1'b0;

    task check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge wb_clk_i) begin
        if (chk_en) begin
            check("ack", 32'(wbs_ack_o), 32'(cyc == e_ack_cyc));
            if (cyc == e_ack_cyc) check("rdata", wbs_dat_o, e_dat);
            check("csb0", 32'(csb0), 32'(cyc != e_sram_cyc));
            if (cyc == e_sram_cyc) begin
                check("web0", 32'(web0), 32'(!e_we));
                check("addr0", 32'(addr0), 32'(e_addr));
                if (e_we) begin
                    check("wmask0", 32'(wmask0), 32'(e_mask));
                    check("din0", din0, e_din);
                end
            end
            check("core_reset", 32'(core_reset_o), 32'(m_hold));
            check("busy", 32'(load_busy_o), 32'(cyc > e_req && cyc <= e_busy_end));
        end
    end

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] wdat, output int lat, output logic [31:0] rdat);
        bit   inblk, ismem, isctrl;
        int   L, idx;
        inblk  = (adr[31:12] == BASE[31:12]);
        ismem  = inblk && (adr[11:0] < 12'h800);
        isctrl = inblk && (adr[11:0] == 12'h800);
        idx    = int'(adr[10:2]);
        if (ismem && we)     L = 2;
        else if (ismem)      L = RB ? 3 : 1;
        else                 L = 1;
        @(posedge wb_clk_i); #1;
        wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = wdat;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        e_req      = cyc;
        e_ack_cyc  = inblk ? cyc + L : -1;
        e_busy_end = inblk ? cyc + L : cyc;
        e_sram_cyc = (ismem && ((we && sel != 4'd0) || (!we && RB))) ? cyc + 1 : -1;
        e_we = we; e_addr = adr[10:2]; e_mask = sel; e_din = wdat;
        if (we || !inblk)  e_dat = 32'd0;
        else if (ismem)    e_dat = RB ? m_mem[idx] : 32'd0;
        else if (isctrl)   e_dat = (m_wcnt << 16) | (m_wseen << 1) | m_hold;
        else               e_dat = 32'd0;
        lat = -1; rdat = 32'hxxxx_xxxx;
        for (int i = 1; i <= 6; i++) begin
            @(posedge wb_clk_i); #1;
            if (i == 1 && we) begin
                if (ismem && sel != 4'd0) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) m_mem[idx][8*b +: 8] = wdat[8*b +: 8];
                    m_wseen = 1;
                    if (m_wcnt < 65535) m_wcnt++;
                end
                if (isctrl && sel[0]) begin
                    m_hold = int'(wdat[0]);
                    if (wdat[1]) begin m_wseen = 0; m_wcnt = 0; end
                end
            end
            if (wbs_ack_o) begin lat = i; rdat = wbs_dat_o; break; end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        if (inblk && lat < 0) check("ack_timeout", 32'(lat), 32'(L));
    endtask

    int          lat;
    logic [31:0] rd;

    initial begin
        for (int i = 0; i < 512; i++) begin sram[i] = 32'd0; m_mem[i] = 32'd0; end
        repeat (3) @(posedge wb_clk_i);
        #1;
        check("rst_csb0", 32'(csb0), 32'd1);
        check("rst_web0", 32'(web0), 32'd1);
        check("rst_core_reset", 32'(core_reset_o), 32'd1);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_busy", 32'(load_busy_o), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        xfer(BASE + 32'h800, 1'b0, 4'hF, 32'd0, lat, rd);
        check("ctrl_rst_lat", 32'(lat), 32'd1);
        check("ctrl_rst_val", rd, 32'h0000_0001);

        xfer(BASE + 32'h010, 1'b1, 4'hF, 32'hDEAD_BEEF, lat, rd);
        check("wr_lat", 32'(lat), 32'd2);
        xfer(BASE + 32'h800, 1'b0, 4'hF, 32'd0, lat, rd);
        check("ctrl_after_wr", rd, 32'h0001_0003);

        xfer(BASE + 32'h7FC, 1'b1, 4'hF, 32'h1234_5678, lat, rd);
        xfer(BASE + 32'h7FC, 1'b0, 4'hF, 32'd0, lat, rd);
`ifdef IMEM_READBACK_EN
        check("rd_top_lat", 32'(lat), 32'd3);
        check("rd_top_val", rd, 32'h1234_5678);
`else
        check("rd_top_lat", 32'(lat), 32'd1);
        check("rd_top_val", rd, 32'h0000_0000);
`endif
        xfer(BASE + 32'h010, 1'b0, 4'hF, 32'd0, lat, rd);

        xfer(BASE + 32'h020, 1'b1, 4'b0010, 32'hAABB_CCDD, lat, rd);
        xfer(BASE + 32'h024, 1'b1, 4'b0000, 32'h5555_5555, lat, rd);
        check("sel0_lat", 32'(lat), 32'd2);
        xfer(BASE + 32'h800, 1'b0, 4'hF, 32'd0, lat, rd);
        check("ctrl_wcnt3", rd, 32'h0003_0003);
        xfer(BASE + 32'h020, 1'b0, 4'hF, 32'd0, lat, rd);
        xfer(BASE + 32'h024, 1'b0, 4'hF, 32'd0, lat, rd);

        xfer(BASE + 32'h800, 1'b1, 4'hF, 32'h0000_0002, lat, rd);
        check("ctrl_wr_lat", 32'(lat), 32'd1);
        check("hold_fell", 32'(core_reset_o), 32'd0);
        xfer(BASE + 32'h800, 1'b0, 4'hF, 32'd0, lat, rd);
        check("ctrl_cleared", rd, 32'h0000_0000);
        xfer(BASE + 32'h800, 1'b1, 4'b1110, 32'h0000_0003, lat, rd);
        xfer(BASE + 32'h800, 1'b0, 4'hF, 32'd0, lat, rd);
        check("ctrl_sel_ignored", rd, 32'h0000_0000);
        xfer(BASE + 32'h800, 1'b1, 4'b0001, 32'h0000_0001, lat, rd);

        xfer(BASE + 32'h900, 1'b0, 4'hF, 32'd0, lat, rd);
        check("unmapped_lat", 32'(lat), 32'd1);
        check("unmapped_val", rd, 32'h0000_0000);
        xfer(BASE + 32'h900, 1'b1, 4'hF, 32'hFFFF_FFFF, lat, rd);
        xfer(32'h3000_1000, 1'b0, 4'hF, 32'd0, lat, rd);
        check("outside_no_ack", 32'(lat), 32'hFFFF_FFFF);
        xfer(BASE + 32'h800, 1'b0, 4'hF, 32'd0, lat, rd);
        check("ctrl_hold_set", rd, 32'h0000_0001);

        // Reset asserted while the SRAM access is in its ISSUE cycle.
        @(posedge wb_clk_i); #1;
        wbs_adr_i = BASE + 32'h040; wbs_sel_i = 4'hF; wbs_dat_i = 32'hCAFE_F00D;
        wbs_we_i = !RB; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        @(posedge wb_clk_i); #1;
        chk_en = 1'b0;
        check("issue_csb_low", 32'(csb0), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_csb0", 32'(csb0), 32'd1);
        check("async_ack", 32'(wbs_ack_o), 32'd0);
        check("async_hold", 32'(core_reset_o), 32'd1);
        check("async_busy", 32'(load_busy_o), 32'd0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        check("rst_hold_ack", 32'(wbs_ack_o), 32'd0);
        rst_n = 1'b1;
        m_hold = 1; m_wseen = 0; m_wcnt = 0;
        e_req = 0; e_busy_end = 0; e_ack_cyc = -1; e_sram_cyc = -1;
        chk_en = 1'b1;
        xfer(BASE + 32'h800, 1'b0, 4'hF, 32'd0, lat, rd);
        check("post_rst_lat", 32'(lat), 32'd1);
        check("post_rst_ctrl", rd, 32'h0000_0001);

        repeat (2) @(posedge wb_clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
        $fatal(1);
    end
endmodule

// File: doc/imem_wb_loader.md
Name: imem_wb_loader

Overview:
Wishbone slave that loads the core's 32x512 instruction SRAM through its read/write port 0, from the management SoC. It drives csb0/web0/wmask0/addr0/din0 and captures dout0 for readback. It also owns a control/status register that holds the RISC-V core in reset while the program is loaded. It sits upstream of the instruction SRAM and replaces bit-banged logic-analyzer loading.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base; the block decodes wbs_adr_i[31:12] == BASE_ADDR[31:12]
ADDR_W, 9, SRAM word-address width (512 words)
DATA_W, 32, SRAM/Wishbone data width

Ports:
wb_clk_i  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic handshake
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  single-cycle acknowledge
wbs_dat_o  out  32  read data, valid only with ack
csb0  out  1  SRAM port-0 chip select, active-low
web0  out  1  SRAM port-0 write enable, active-low
wmask0  out  4  SRAM byte write mask
addr0  out  ADDR_W  SRAM word address
din0  out  DATA_W  SRAM write data
dout0  in  DATA_W  SRAM read data, valid 1 cycle after the read is issued
core_reset_o  out  1  active-high reset to core = CTRL.HOLD
load_busy_o  out  1  high when FSM not IDLE

Behaviour:
- Reset values: csb0=1, web0=1, wmask0=0, addr0=0, din0=0, wbs_ack_o=0, wbs_dat_o=0, core_reset_o=1 (HOLD=1), load_busy_o=0, WCNT=0, state=IDLE. All SRAM outputs are registered.
- Decode (offset = wbs_adr_i[11:0]): 0x000-0x7FC memory window, word index = adr[10:2], adr[1:0] ignored; 0x800 CTRL; other offsets in block = unmapped. Outside the block: no response.
- CTRL: bit0 HOLD (rw); bit1 WSEEN (ro, set by any memory write that carries a non-zero sel, cleared by a CTRL write with bit1=1); bits[31:16] WCNT (ro, memory writes with non-zero sel, saturates at 0xFFFF, cleared together with WSEEN). Other bits read 0.
- FSM states: IDLE, ISSUE, WAIT, ACK. A request is accepted only in IDLE, with cyc&stb high and a decoded address.
- Memory write: IDLE->ISSUE: csb0=0, web0=0, wmask0=sel, addr0/din0 latched. ISSUE->ACK: csb0=1, web0=1. ACK asserts wbs_ack_o for 1 cycle, then returns to IDLE. Ack occurs 2 cycles after acceptance.
- sel==0 write: follows the same timing, but csb0 stays 1 and WCNT/WSEEN are unchanged.
- Memory read: IDLE->ISSUE (csb0=0, web0=1) ->WAIT (csb0=1) ->ACK with wbs_dat_o=dout0 captured at WAIT. Ack occurs 3 cycles after acceptance.
- CTRL and unmapped accesses: IDLE->ACK directly (ack 1 cycle after acceptance). Unmapped reads return 0 and unmapped writes are dropped. CTRL writes honour sel byte 0 only.
- wbs_ack_o is a 1-cycle pulse. After ACK the FSM is in IDLE, and a still-asserted stb is treated as a new request.
- cyc dropped mid-transaction: any in-flight SRAM access completes, the ack is suppressed, and the FSM returns to IDLE.
- WCNT at 0xFFFF plus a write: stays at 0xFFFF.
- rst_n low at any time: all state clears immediately, including an in-flight access (csb0 goes to 1 asynchronously), and HOLD returns to 1.
- The block never touches SRAM port 1; the core fetches there, and it is held in reset while HOLD=1.

Optional Feature:
IMEM_READBACK_EN — defined: memory-window reads perform the SRAM read path above. Undefined: memory-window reads skip the SRAM, go IDLE->ACK and return 0; csb0 is asserted only for writes, and the WAIT state and the dout0 capture register are not built.

Test Plan:
Reset: assert rst_n=0 -> csb0=1, web0=1, core_reset_o=1, wbs_ack_o=0; read CTRL -> 0x0000_0001.
Write 0xDEADBEEF to BASE+0x010 with sel=4'hF -> csb0=0/web0=0 for exactly 1 cycle, addr0=4, wmask0=F, ack 2 cycles after acceptance; CTRL then reads 0x0001_0003.
With IMEM_READBACK_EN: write 0x12345678 to BASE+0x7FC, then read it back -> addr0=511, ack 3 cycles after acceptance, wbs_dat_o=0x12345678. Without the macro: same read -> ack after 1 cycle, data=0, csb0 never low.
sel=4'b0010 write -> wmask0=2. sel=0 write -> ack after 2 cycles, csb0 stays 1, WCNT unchanged.
Write CTRL=0x2 -> WSEEN/WCNT cleared and HOLD cleared, so core_reset_o falls on that ack. Access to BASE+0x900 -> ack after 1 cycle, read data 0. Access to 0x3000_1000 -> no ack.
Pull rst_n low during a read's ISSUE cycle -> csb0=1 immediately, no ack; after release, HOLD=1 and the FSM is in IDLE.
